// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered one-hot grant and zero-bubble handoff.
// Optional per-grant hold limit is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic                 timeout
);
   localparam int IDW = $clog2(N);
   localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {IDLE = 1'b0, OWNED = 1'b1} state_t;

   state_t         state_r, state_s;
   logic [N-1:0]   gnt_r, gnt_s, elig_s;
   logic [IDW-1:0] id_r, id_s, ptr_r, ptr_s, win_s;
   logic [IDW:0]   pick_s;
   logic           busy_r, win_vld_s, owner_req_s, hold_hit_s, arb_s;

   if (N < 2) begin : g_bad_n
      $error("rr_arbiter: N must be at least 2");
   end
   if (MAX_HOLD < 1) begin : g_bad_hold
      $error("rr_arbiter: MAX_HOLD must be at least 1");
   end

   // First set bit of r searching p+1, p+2, ... mod N; MSB of the result flags a hit.
   function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
      logic [IDW:0]   res;
      logic [IDW-1:0] idx;
      res = {(IDW+1){1'b0}};
      for (int i = N; i >= 1; i--) begin
         idx = IDW'((int'(p) + i) % N);
         if (r[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign owner_req_s = |(req & gnt_r);

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD + 1);
   logic [CW-1:0] cnt_r, cnt_s;
   logic          timeout_r;

   assign hold_hit_s = (state_r == OWNED) && owner_req_s && (cnt_r == CW'(MAX_HOLD));

   // Hold counter: 1 on a fresh grant, +1 for every cycle the grant is kept.
   always_comb begin
      if (arb_s && win_vld_s) begin
         cnt_s = CW'(1);
      end else if (state_s == OWNED) begin
         cnt_s = cnt_r + CW'(1);
      end else begin
         cnt_s = {CW{1'b0}};
      end
   end

   // Hold counter and revoke pulse registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r     <= {CW{1'b0}};
         timeout_r <= 1'b0;
      end else begin
         cnt_r     <= cnt_s;
         timeout_r <= hold_hit_s;
      end
   end

   assign timeout = timeout_r;
`else
   assign hold_hit_s = 1'b0;
   assign timeout    = 1'b0;
`endif

   // Arbitration: a revoked owner is masked out so it cannot immediately win again.
   always_comb begin
      elig_s    = hold_hit_s ? (req & ~gnt_r) : req;
      pick_s    = rr_pick(elig_s, ptr_r);
      win_vld_s = pick_s[IDW];
      win_s     = pick_s[IDW-1:0];
      arb_s     = (state_r != OWNED) || !owner_req_s || hold_hit_s;
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = win_vld_s ? OWNED : IDLE;
         OWNED:   state_s = (!arb_s || win_vld_s) ? OWNED : IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Next grant, owner index and pointer; gnt_id keeps its last value when idle.
   always_comb begin
      gnt_s = gnt_r;
      id_s  = id_r;
      ptr_s = ptr_r;
      if (arb_s && win_vld_s) begin
         gnt_s = ONE_HOT0 << win_s;
         id_s  = win_s;
         ptr_s = win_s;
      end else if (state_s == IDLE) begin
         gnt_s = {N{1'b0}};
      end else begin
         gnt_s = gnt_r;
      end
   end

   // State and output registers; ptr resets to N-1 so requester 0 is searched first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         gnt_r   <= {N{1'b0}};
         id_r    <= {IDW{1'b0}};
         ptr_r   <= IDW'(N - 1);
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         gnt_r   <= gnt_s;
         id_r    <= id_s;
         ptr_r   <= ptr_s;
         busy_r  <= |gnt_s;
      end
   end

   assign gnt    = gnt_r;
   assign gnt_id = id_r;
   assign busy   = busy_r;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed and random stimulus checked against a behavioural round-robin model.
module tb_rr_arbiter;
   localparam int N        = 4;
   localparam int MAX_HOLD = 8;
   localparam int IDW      = $clog2(N);
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           busy;
   logic           timeout;

   int total = 0;
   int bad   = 0;

   // Reference state: owner index (-1 = idle), last granted index, shown id, cycles held.
   int m_owner, m_ptr, m_id, m_held;
   bit m_to;

   rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
      .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit has(input logic [N-1:0] v, input int i);
      return |(v & (ONE << i));
   endfunction

   task automatic model_step(input logic r, input logic [N-1:0] rq);
      int excl;
      int w;
      int c;
      m_to = 1'b0;
      if (!r) begin
         m_owner = -1; m_ptr = N - 1; m_id = 0; m_held = 0;
      end else if (m_owner >= 0 && has(rq, m_owner) && !(TO_EN && m_held == MAX_HOLD)) begin
         m_held++;
      end else begin
         excl = -1;
         if (m_owner >= 0 && has(rq, m_owner)) begin
            excl = m_owner;
            m_to = 1'b1;
         end
         w = -1;
         for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (w < 0 && has(rq, c) && c != excl) w = c;
         end
         if (w >= 0) begin
            m_owner = w; m_ptr = w; m_id = w; m_held = 1;
         end else begin
            m_owner = -1; m_held = 0;
         end
      end
   endtask

   task automatic step(input logic r, input logic [N-1:0] rq);
      logic [N-1:0] eg;
      rst_n = r;
      req   = rq;
      @(posedge clk);
      model_step(r, rq);
      #1;
      eg = (m_owner >= 0) ? (ONE << m_owner) : {N{1'b0}};
      check_val("gnt", 32'(gnt), 32'(eg));
      check_val("gnt_id", 32'(gnt_id), 32'(m_id));
      check_val("busy", 32'(busy), 32'(m_owner >= 0));
      check_val("timeout", 32'(timeout), 32'(m_to));
   endtask

   task automatic do_reset();
      step(1'b0, 4'b1111);
      step(1'b0, 4'b1111);
      check_val("rst_gnt", 32'(gnt), 32'h0);
      check_val("rst_busy", 32'(busy), 32'h0);
      check_val("rst_timeout", 32'(timeout), 32'h0);
   endtask

   initial begin
      logic [N-1:0] rq;
      int           exp_own;
      rst_n   = 1'b0;
      req     = {N{1'b0}};
      m_owner = -1; m_ptr = N - 1; m_id = 0; m_held = 0; m_to = 1'b0;

      // Reset with all requesting, then release: requester 0 first.
      do_reset();
      step(1'b1, 4'b1111);
      check_val("rel_gnt", 32'(gnt), 32'h1);
      check_val("rel_id", 32'(gnt_id), 32'h0);

      // Rotation: each owner drops its request for one cycle after two cycles of ownership.
      for (int k = 1; k <= 9; k++) begin
         exp_own = ((k - 1) / 2) % N;
         rq = 4'b1111;
         if ((k - 1) % 2 == 1) rq = rq & ~(ONE << exp_own);
         step(1'b1, rq);
         check_val("rot_id", 32'(gnt_id), 32'((k / 2) % N));
         check_val("rot_busy", 32'(busy), 32'h1);
      end

      // Sparse priority with ptr=1: index 3 beats 0, then 0 follows.
      do_reset();
      step(1'b1, 4'b0010);
      check_val("sp_own1", 32'(gnt), 32'h2);
      step(1'b1, 4'b1001);
      check_val("sp_3first", 32'(gnt), 32'h8);
      step(1'b1, 4'b0001);
      check_val("sp_then0", 32'(gnt), 32'h1);

      // Single requester release and re-request: one idle cycle in between.
      step(1'b1, 4'b0000);
      check_val("single_idle", 32'(gnt), 32'h0);
      step(1'b1, 4'b0001);
      check_val("single_again", 32'(gnt), 32'h1);

      // Hold: requester 2 keeps the grant while all request.
      do_reset();
      step(1'b1, 4'b0100);
      for (int k = 0; k < 20; k++) begin
         step(1'b1, 4'b1111);
`ifndef ARB_TIMEOUT_EN
         check_val("hold_gnt", 32'(gnt), 32'h4);
`endif
      end

`ifdef ARB_TIMEOUT_EN
      // Hold limit: two requesters alternate every MAX_HOLD cycles with a one-cycle pulse.
      do_reset();
      for (int j = 0; j < 3 * MAX_HOLD; j++) begin
         step(1'b1, 4'b0011);
         check_val("to_gnt", 32'(gnt), 32'(ONE << ((j / MAX_HOLD) % 2)));
         check_val("to_pulse", 32'(timeout), 32'(j > 0 && (j % MAX_HOLD) == 0));
      end
`endif

      // Mid-grant reset: pointer returns to N-1, so requester 1 wins over 2.
      do_reset();
      step(1'b1, 4'b0100);
      check_val("mid_own2", 32'(gnt), 32'h4);
      step(1'b0, 4'b0110);
      check_val("mid_rst", 32'(gnt), 32'h0);
      step(1'b1, 4'b0110);
      check_val("mid_after", 32'(gnt), 32'h2);

      // Random traffic, biased towards owners holding, with rare resets.
      for (int k = 0; k < 600; k++) begin
         rq = N'($urandom);
         if (m_owner >= 0 && $urandom_range(0, 9) < 7) rq = rq | (ONE << m_owner);
         if ($urandom_range(0, 7) == 0) rq = {N{1'b0}};
         step(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1, rq);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
